cpu_run_controller: RTL and testbench

- Sequences execution of the single-cycle core by generating its per-instruction enable.
- Supports four modes: halted, single-step, free-run at a visible rate, and fixed-length burst.
- Sits between the button conditioning chain (debounce -> sync -> one-period pulse) and the core's enable input.
- Adds PC breakpoint and core halt-request (ebreak) stopping, plus a retired-instruction counter for debug/LED display.

---
 rtl/cpu_run_controller.sv | 172 +++++++++++++++++
 tb/tb_cpu_run_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// -----------------------------------------------------------------------------
// cpu_run_controller
//
// Generates the per-instruction enable for the single-cycle core. Four modes:
// HALT (no enables), STEP (one enable), RUN (one enable every RUN_DIV cycles)
// and BURST (BURST_LEN back-to-back enables). RUN and BURST stop on a PC
// breakpoint or on the core's halt request (ebreak). A retired-instruction
// counter tracks every enable issued since reset.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        synchronous active-low reset
//   i_step_pulse   one-cycle pulse: execute one instruction
//   i_run_pulse    one-cycle pulse: start RUN from HALT, stop RUN/BURST
//   i_burst_pulse  one-cycle pulse: execute BURST_LEN instructions
//   i_pc           PC of the next instruction the core will execute
//   i_bp_addr      breakpoint address
//   i_bp_en        breakpoint enable
//   i_halt_req     core decode says the next instruction is ebreak
//   o_cpu_en       registered core enable, one instruction per high cycle
//   o_state        HALT=00, STEP=01, RUN=10, BURST=11
//   o_instr_count  enables issued since reset, wraps
//   o_bp_hit       sticky: last RUN/BURST stopped on the breakpoint
//
// Handshake: none; the pulses are single-cycle strobes sampled on the rising
// edge. Pulses that are not meaningful in the current state are dropped.
// -----------------------------------------------------------------------------
module cpu_run_controller #(
   parameter int RUN_DIV   = 50000000,
   parameter int BURST_LEN = 8,
   parameter int CNT_W     = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_step_pulse,
   input  logic             i_run_pulse,
   input  logic             i_burst_pulse,
   input  logic [31:0]      i_pc,
   input  logic [31:0]      i_bp_addr,
   input  logic             i_bp_en,
   input  logic             i_halt_req,
   output logic             o_cpu_en,
   output logic [1:0]       o_state,
   output logic [CNT_W-1:0] o_instr_count,
   output logic             o_bp_hit
);

   localparam logic [1:0] S_HALT  = 2'b00;
   localparam logic [1:0] S_STEP  = 2'b01;
   localparam logic [1:0] S_RUN   = 2'b10;
   localparam logic [1:0] S_BURST = 2'b11;

   // Prescaler needs at least one bit even when RUN_DIV is 1.
   localparam int PW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
   localparam int BW = $clog2(BURST_LEN + 1);

   localparam logic [PW-1:0] PRESC_MAX = PW'(RUN_DIV - 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);

   logic [1:0]       r_state;
   logic             r_cpu_en;
   logic [PW-1:0]    r_presc;
   logic [BW-1:0]    r_bcnt;   // enables already issued in this burst
   logic [CNT_W-1:0] r_count;
   logic             r_bp_hit;

   logic [1:0]       w_state_next;
   logic             w_cpu_en_next;
   logic [PW-1:0]    w_presc_next;
   logic [BW-1:0]    w_bcnt_next;
   logic             w_bp_hit_next;

   logic             w_bp_match;
   logic             w_stop;
   logic             w_presc_wrap;
   logic             w_burst_done;
   logic             w_any_pulse;

   assign w_bp_match   = i_bp_en && (i_pc == i_bp_addr);
   assign w_stop       = i_halt_req || w_bp_match;
   assign w_presc_wrap = (r_presc == PRESC_MAX);
   assign w_burst_done = (r_bcnt == BURST_MAX);
   assign w_any_pulse  = i_run_pulse || i_burst_pulse || i_step_pulse;

   // State register plus the registered outputs that move with it.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state  <= S_HALT;
         r_cpu_en <= 1'b0;
         r_presc  <= '0;
         r_bcnt   <= '0;
         r_count  <= '0;
         r_bp_hit <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_cpu_en <= w_cpu_en_next;
         r_presc  <= w_presc_next;
         r_bcnt   <= w_bcnt_next;
         r_count  <= r_count + CNT_W'(r_cpu_en);
         r_bp_hit <= w_bp_hit_next;
      end
   end

   // Next-state logic. Run pulse wins over any coincident enable or stop.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_HALT: begin
            if (i_run_pulse)        w_state_next = S_RUN;
            else if (i_burst_pulse) w_state_next = S_BURST;
            else if (i_step_pulse)  w_state_next = S_STEP;
         end
         S_STEP: w_state_next = S_HALT;
         S_RUN: begin
            if (i_run_pulse)                 w_state_next = S_HALT;
            else if (w_presc_wrap && w_stop) w_state_next = S_HALT;
         end
         S_BURST: begin
            if (i_run_pulse || w_burst_done || w_stop) w_state_next = S_HALT;
         end
         default: w_state_next = S_HALT;
      endcase
   end

   // Output logic: values the output registers take at the next edge.
   // Entering STEP/RUN/BURST issues the first enable unconditionally, so
   // stepping or resuming from a breakpoint/ebreak always makes progress.
   always_comb begin
      w_cpu_en_next = 1'b0;
      w_presc_next  = r_presc;
      w_bcnt_next   = r_bcnt;
      w_bp_hit_next = r_bp_hit;
      case (r_state)
         S_HALT: begin
            if (w_any_pulse) begin
               w_cpu_en_next = 1'b1;
               w_bp_hit_next = 1'b0;
            end
            if (i_run_pulse)        w_presc_next = '0;
            else if (i_burst_pulse) w_bcnt_next  = BW'(1);
         end
         S_RUN: begin
            if (!i_run_pulse) begin
               if (w_presc_wrap) begin
                  w_presc_next = '0;
                  if (w_stop) w_bp_hit_next = r_bp_hit || w_bp_match;
                  else        w_cpu_en_next = 1'b1;
               end else begin
                  w_presc_next = r_presc + PW'(1);
               end
            end
         end
         S_BURST: begin
            if (!i_run_pulse && !w_burst_done) begin
               if (w_stop) begin
                  w_bp_hit_next = r_bp_hit || w_bp_match;
               end else begin
                  w_cpu_en_next = 1'b1;
                  w_bcnt_next   = r_bcnt + BW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   assign o_cpu_en      = r_cpu_en;
   assign o_state       = r_state;
   assign o_instr_count = r_count;
   assign o_bp_hit      = r_bp_hit;

endmodule

// File: tb/tb_cpu_run_controller.sv
module tb_cpu_run_controller;

  localparam int RUN_DIV   = 4;
  localparam int BURST_LEN = 3;
  localparam int CNT_W     = 8;

  localparam int M_HALT  = 0;
  localparam int M_STEP  = 1;
  localparam int M_RUN   = 2;
  localparam int M_BURST = 3;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             i_rst_n = 1'b0;
  logic             i_step_pulse = 1'b0;
  logic             i_run_pulse = 1'b0;
  logic             i_burst_pulse = 1'b0;
  logic [31:0]      i_pc = 32'h0;
  logic [31:0]      i_bp_addr = 32'h0;
  logic             i_bp_en = 1'b0;
  logic             i_halt_req = 1'b0;
  logic             o_cpu_en;
  logic [1:0]       o_state;
  logic [CNT_W-1:0] o_instr_count;
  logic             o_bp_hit;

  cpu_run_controller #(
    .RUN_DIV(RUN_DIV), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_step_pulse(i_step_pulse), .i_run_pulse(i_run_pulse),
    .i_burst_pulse(i_burst_pulse), .i_pc(i_pc), .i_bp_addr(i_bp_addr),
    .i_bp_en(i_bp_en), .i_halt_req(i_halt_req),
    .o_cpu_en(o_cpu_en), .o_state(o_state),
    .o_instr_count(o_instr_count), .o_bp_hit(o_bp_hit)
  );

  int checks = 0;
  int errors = 0;

  // behavioural reference: mode, cycles since RUN began, enables issued in burst
  int               m_mode = M_HALT;
  int               m_since = 0;
  int               m_issued = 0;
  bit               m_en = 1'b0;
  bit               m_bp = 1'b0;
  logic [CNT_W-1:0] m_count = '0;

  function automatic void model_edge(bit st, bit ru, bit bu, logic [31:0] pc,
                                     bit hr, bit rn);
    bit bp_term;
    bit stop;
    bp_term = i_bp_en && (pc == i_bp_addr);
    stop    = hr || bp_term;
    if (!rn) begin
      m_mode = M_HALT; m_en = 0; m_bp = 0; m_count = '0; m_since = 0; m_issued = 0;
      return;
    end
    if (m_en) m_count = m_count + 1'b1;
    case (m_mode)
      M_HALT: begin
        m_en = 0;
        if (ru)      begin m_mode = M_RUN;   m_since = 0;  m_en = 1; m_bp = 0; end
        else if (bu) begin m_mode = M_BURST; m_issued = 1; m_en = 1; m_bp = 0; end
        else if (st) begin m_mode = M_STEP;  m_en = 1; m_bp = 0; end
      end
      M_STEP: begin m_mode = M_HALT; m_en = 0; end
      M_RUN: begin
        m_since = m_since + 1;
        m_en = 0;
        if (ru) m_mode = M_HALT;
        else if (m_since % RUN_DIV == 0) begin
          if (stop) begin m_mode = M_HALT; if (bp_term) m_bp = 1; end
          else m_en = 1;
        end
      end
      default: begin
        m_en = 0;
        if (ru || m_issued == BURST_LEN) m_mode = M_HALT;
        else if (stop) begin m_mode = M_HALT; if (bp_term) m_bp = 1; end
        else begin m_en = 1; m_issued = m_issued + 1; end
      end
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: apply one cycle of inputs, advance the model, compare after the edge
  task automatic tick(bit st, bit ru, bit bu, logic [31:0] pc, bit hr, bit rn);
    i_step_pulse  = st;
    i_run_pulse   = ru;
    i_burst_pulse = bu;
    i_pc          = pc;
    i_halt_req    = hr;
    i_rst_n       = rn;
    model_edge(st, ru, bu, pc, hr, rn);
    @(posedge clk);
    #1;
    check("cpu_en", 32'(o_cpu_en), 32'(m_en));
    check("state", 32'(o_state), 32'(m_mode));
    check("count", 32'(o_instr_count), 32'(m_count));
    check("bp_hit", 32'(o_bp_hit), 32'(m_bp));
    @(negedge clk);
    i_step_pulse  = 1'b0;
    i_run_pulse   = 1'b0;
    i_burst_pulse = 1'b0;
  endtask

  task automatic idle(int n, logic [31:0] pc, bit hr);
    for (int i = 0; i < n; i++) tick(0, 0, 0, pc, hr, 1);
  endtask

  task automatic do_reset();
    tick(0, 0, 0, 32'h0, 0, 0);
    tick(0, 0, 0, 32'h0, 0, 0);
  endtask

  logic [31:0] pc_tab [3];

  initial begin
    pc_tab[0] = 32'h0C; pc_tab[1] = 32'h10; pc_tab[2] = 32'h14;
    @(negedge clk);

    // reset and idle
    do_reset();
    check("rst_state", 32'(o_state), 32'h0);
    check("rst_count", 32'(o_instr_count), 32'h0);
    idle(20, 32'h0, 0);

    // single steps
    idle(9, 32'h0, 0);
    tick(1, 0, 0, 32'h0, 0, 1);
    check("step_en_hi", 32'(o_cpu_en), 32'h1);
    idle(1, 32'h0, 0);
    check("step_en_lo", 32'(o_cpu_en), 32'h0);
    check("step_halt", 32'(o_state), 32'h0);
    check("step_cnt1", 32'(o_instr_count), 32'h1);
    tick(1, 0, 0, 32'h0, 0, 1);
    idle(2, 32'h0, 0);
    check("step_cnt2", 32'(o_instr_count), 32'h2);

    // free run, stopped by the run pulse
    do_reset();
    tick(0, 1, 0, 32'h0, 0, 1);
    idle(13, 32'h0, 0);
    tick(0, 1, 0, 32'h0, 0, 1);
    idle(4, 32'h0, 0);
    check("run_cnt4", 32'(o_instr_count), 32'h4);

    // breakpoint stop, then step past it
    do_reset();
    i_bp_en = 1'b1; i_bp_addr = 32'h10;
    tick(0, 1, 0, 32'h0C, 0, 1);
    idle(4, 32'h0C, 0);
    idle(6, 32'h10, 0);
    check("bp_hit_set", 32'(o_bp_hit), 32'h1);
    check("bp_cnt2", 32'(o_instr_count), 32'h2);
    tick(1, 0, 0, 32'h10, 0, 1);
    check("bp_cleared", 32'(o_bp_hit), 32'h0);
    check("bp_step_en", 32'(o_cpu_en), 32'h1);
    idle(2, 32'h10, 0);
    i_bp_en = 1'b0;

    // bursts: full, then cut short by halt request
    do_reset();
    tick(0, 0, 1, 32'h0, 0, 1);
    idle(5, 32'h0, 0);
    check("burst_cnt3", 32'(o_instr_count), 32'h3);
    tick(0, 0, 1, 32'h0, 0, 1);
    idle(4, 32'h0, 1);
    check("burst_hr_cnt4", 32'(o_instr_count), 32'h4);
    check("burst_hr_bp", 32'(o_bp_hit), 32'h0);

    // counter wrap
    do_reset();
    for (int i = 0; i < 255; i++) begin
      tick(1, 0, 0, 32'h0, 0, 1);
      idle(1, 32'h0, 0);
    end
    idle(1, 32'h0, 0);
    check("cnt_255", 32'(o_instr_count), 32'hFF);
    tick(1, 0, 0, 32'h0, 0, 1);
    idle(2, 32'h0, 0);
    check("cnt_wrap", 32'(o_instr_count), 32'h0);

    // reset mid-run
    tick(0, 1, 0, 32'h0, 0, 1);
    idle(6, 32'h0, 0);
    tick(0, 0, 0, 32'h0, 0, 0);
    check("midrst_en", 32'(o_cpu_en), 32'h0);
    check("midrst_state", 32'(o_state), 32'h0);
    check("midrst_cnt", 32'(o_instr_count), 32'h0);

    // coincident run + step in HALT
    tick(1, 1, 0, 32'h0, 0, 1);
    check("prio_run", 32'(o_state), 32'h2);
    tick(0, 1, 0, 32'h0, 0, 1);
    idle(2, 32'h0, 0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(49, 0) == 0) begin
        i_bp_en   = 1'($urandom_range(1, 0));
        i_bp_addr = pc_tab[$urandom_range(2, 0)];
      end
      tick($urandom_range(7, 0) == 0, $urandom_range(11, 0) == 0,
           $urandom_range(7, 0) == 0, pc_tab[$urandom_range(2, 0)],
           $urandom_range(9, 0) == 0, $urandom_range(149, 0) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
